// File: rtl/flash_arb.sv
// Purpose: two-port round-robin arbiter/sequencer sharing one SPI flash controller (port 0 = CPU, port 1 = boot loader).
// Latency: strobe 1 cycle after grant; ack 2 cycles after busy is sampled low, or START_TIMEOUT+2 cycles after the strobe if busy never rises.
// Backpressure: requesters hold req until their ack pulse; no grant while flash_busy is high. Define FLASH_ARB_FIXED_PRIO_EN for strict port-0 priority.
module flash_arb #(
    parameter int START_TIMEOUT = 8,
    parameter int TO_W          = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [7:0]  wdata0,
    output logic        ack0,
    input  logic        req1,
    input  logic        we1,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata1,
    output logic        ack1,
    output logic [7:0]  rdata,
    output logic        err,
    output logic        gnt,
    output logic        active,
    output logic        flash_read,
    output logic        flash_write,
    output logic [15:0] flash_addr,
    output logic [7:0]  flash_din,
    input  logic [7:0]  flash_dout,
    input  logic        flash_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              err_pend_q, err_pend_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              err_q, err_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              gnt_q, gnt_d;
    logic              active_q, active_d;
    logic              flash_read_q, flash_read_d;
    logic              flash_write_q, flash_write_d;
    logic [15:0]       flash_addr_q, flash_addr_d;
    logic [7:0]        flash_din_q, flash_din_d;
`ifndef FLASH_ARB_FIXED_PRIO_EN
    logic              last_gnt_q, last_gnt_d;
`endif

    logic              grant_vld;
    logic              sel;
    logic              sel_we;

    // Port selection: only meaningful when grant_vld is set
    always_comb begin
        sel = 1'b0;
`ifdef FLASH_ARB_FIXED_PRIO_EN
        sel = !req0;
`else
        if (req0 && req1) begin
            sel = !last_gnt_q;
        end else begin
            sel = !req0;
        end
`endif
        sel_we    = sel ? we1 : we0;
        grant_vld = !flash_busy && (req0 || req1);
    end

    // All state and output flops; reset abandons any transaction silently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            err_pend_q    <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            gnt_q         <= 1'b0;
            active_q      <= 1'b0;
            flash_read_q  <= 1'b0;
            flash_write_q <= 1'b0;
            flash_addr_q  <= '0;
            flash_din_q   <= '0;
`ifndef FLASH_ARB_FIXED_PRIO_EN
            last_gnt_q    <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_pend_q    <= err_pend_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            gnt_q         <= gnt_d;
            active_q      <= active_d;
            flash_read_q  <= flash_read_d;
            flash_write_q <= flash_write_d;
            flash_addr_q  <= flash_addr_d;
            flash_din_q   <= flash_din_d;
`ifndef FLASH_ARB_FIXED_PRIO_EN
            last_gnt_q    <= last_gnt_d;
`endif
        end
    end

    // Next-state: one pass IDLE -> ISSUE -> WAIT_BUSY -> (WAIT_DONE) -> DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (flash_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == TO_W'(START_TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!flash_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; strobes and ack default low so each is a single-cycle pulse
    always_comb begin
        cnt_d         = cnt_q;
        err_pend_d    = err_pend_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        err_d         = 1'b0;
        rdata_d       = rdata_q;
        gnt_d         = gnt_q;
        active_d      = active_q;
        flash_read_d  = 1'b0;
        flash_write_d = 1'b0;
        flash_addr_d  = flash_addr_q;
        flash_din_d   = flash_din_q;
`ifndef FLASH_ARB_FIXED_PRIO_EN
        last_gnt_d    = last_gnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    gnt_d         = sel;
                    flash_addr_d  = sel ? addr1 : addr0;
                    flash_din_d   = sel ? wdata1 : wdata0;
                    flash_write_d = sel_we;
                    flash_read_d  = !sel_we;
                    active_d      = 1'b1;
`ifndef FLASH_ARB_FIXED_PRIO_EN
                    last_gnt_d    = sel;
`endif
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
            end
            ST_WAIT_BUSY: begin
                if (!flash_busy) begin
                    if (cnt_q == TO_W'(START_TIMEOUT - 1)) begin
                        err_pend_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + TO_W'(1);
                    end
                end
            end
            ST_WAIT_DONE: begin
                // Captured for writes too; the requester ignores it then
                if (!flash_busy) begin
                    rdata_d    = flash_dout;
                    err_pend_d = 1'b0;
                end
            end
            ST_DONE: begin
                ack0_d   = !gnt_q;
                ack1_d   = gnt_q;
                err_d    = err_pend_q;
                active_d = 1'b0;
            end
            default: begin
                active_d = 1'b0;
            end
        endcase
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign gnt         = gnt_q;
    assign active      = active_q;
    assign flash_read  = flash_read_q;
    assign flash_write = flash_write_q;
    assign flash_addr  = flash_addr_q;
    assign flash_din   = flash_din_q;

endmodule

// File: tb/tb_flash_arb.sv
// Purpose: directed self-checking bench for flash_arb with a behavioural flash_ctl busy model.
// Latency: checks strobe/ack cycle offsets against hand-derived values.
// Backpressure: requesters hold req until ack; busy model and external busy override.
module tb_flash_arb;

    localparam int START_TIMEOUT = 8;
`ifdef FLASH_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0;
    logic [7:0]  wdata0 = 0, wdata1 = 0;
    logic        ack0, ack1, err, gnt, active, flash_read, flash_write;
    logic [7:0]  rdata, flash_din;
    logic [15:0] flash_addr;
    logic [7:0]  flash_dout = 8'h00;
    logic        flash_busy;

    flash_arb #(.START_TIMEOUT(START_TIMEOUT), .TO_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .err(err), .gnt(gnt), .active(active),
        .flash_read(flash_read), .flash_write(flash_write),
        .flash_addr(flash_addr), .flash_din(flash_din),
        .flash_dout(flash_dout), .flash_busy(flash_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // flash_ctl model: busy rises the cycle after a strobe and stays high busy_len cycles
    int busy_len = 3;
    bit model_dead = 1'b0;
    bit ext_busy = 1'b0;
    int bcnt = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) bcnt <= 0;
        else if ((flash_read || flash_write) && !model_dead) bcnt <= busy_len;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign flash_busy = ext_busy | (bcnt != 0);

    // Monitor: strobe/ack bookkeeping sampled on the falling edge
    int          n_rd = 0, n_wr = 0, n_both = 0, n_ack0 = 0, n_ack1 = 0;
    logic [15:0] strb_addr = 0;
    logic [7:0]  strb_din = 0, ack_rd = 0;
    logic        strb_gnt = 0, ack_err = 0;
    int          strb_cyc = 0, ack_cyc = 0;
    bit          gq[$];
    always @(negedge clk) begin
        if (flash_read) n_rd <= n_rd + 1;
        if (flash_write) n_wr <= n_wr + 1;
        if (flash_read && flash_write) n_both <= n_both + 1;
        if (flash_read || flash_write) begin
            strb_addr <= flash_addr;
            strb_din  <= flash_din;
            strb_gnt  <= gnt;
            strb_cyc  <= cyc;
            gq.push_back(gnt);
        end
        if (ack0) n_ack0 <= n_ack0 + 1;
        if (ack1) n_ack1 <= n_ack1 + 1;
        if (ack0 || ack1) begin
            ack_cyc <= cyc;
            ack_err <= err;
            ack_rd  <= rdata;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic start_req(input bit port, input bit we, input logic [15:0] a, input logic [7:0] d);
        if (!port) begin
            we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
    endtask

    task automatic wait_ack(input bit port, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (port ? ack1 : ack0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!port) req0 = 1'b0;
        else req1 = 1'b0;
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int b_rd, b_wr, b_a0, b_a1, acks, c_rel;
        bit first_seen, first_g, done0, done1;

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        check("rst_ctl", {25'd0, ack0, ack1, err, gnt, active, flash_read, flash_write}, 32'd0);
        check("rst_dat", {rdata, flash_addr, flash_din}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // Single read on port 0
        busy_len = 40; flash_dout = 8'hA5;
        b_rd = n_rd; b_wr = n_wr; b_a0 = n_ack0; b_a1 = n_ack1;
        start_req(0, 0, 16'h0123, 8'h00);
        wait_ack(0, "rd_ack_seen");
        idle(3);
        check("rd_strobes", 32'(n_rd - b_rd), 32'd1);
        check("rd_no_write", 32'(n_wr - b_wr), 32'd0);
        check("rd_addr", 32'(strb_addr), 32'h0123);
        check("rd_gnt", 32'(strb_gnt), 32'd0);
        check("rd_ack0_once", 32'(n_ack0 - b_a0), 32'd1);
        check("rd_no_ack1", 32'(n_ack1 - b_a1), 32'd0);
        check("rd_data", 32'(ack_rd), 32'hA5);
        check("rd_err", 32'(ack_err), 32'd0);
        check("rd_latency", 32'(ack_cyc - strb_cyc), 32'd43);
        check("rd_inactive", 32'(active), 32'd0);

        // Single write on port 1
        busy_len = 3;
        b_rd = n_rd; b_wr = n_wr; b_a0 = n_ack0; b_a1 = n_ack1;
        start_req(1, 1, 16'h07FF, 8'h3C);
        wait_ack(1, "wr_ack_seen");
        idle(3);
        check("wr_strobes", 32'(n_wr - b_wr), 32'd1);
        check("wr_no_read", 32'(n_rd - b_rd), 32'd0);
        check("wr_addr", 32'(strb_addr), 32'h07FF);
        check("wr_din", 32'(strb_din), 32'h3C);
        check("wr_gnt", 32'(strb_gnt), 32'd1);
        check("wr_ack1_once", 32'(n_ack1 - b_a1), 32'd1);
        check("wr_no_ack0", 32'(n_ack0 - b_a0), 32'd0);
        check("wr_err", 32'(ack_err), 32'd0);

        // Contention: both held for four transactions
        gq.delete();
        b_a0 = n_ack0; b_a1 = n_ack1;
        addr0 = 16'h0100; addr1 = 16'h0200; we0 = 0; we1 = 0;
        req0 = 1'b1; req1 = 1'b1;
        acks = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            acks += int'(ack0) + int'(ack1);
            if (acks >= 4) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        idle(4);
        check("cont_acks", 32'(acks), 32'd4);
        check("cont_grants", 32'(gq.size()), 32'd4);
        for (int i = 0; i < gq.size() && i < 4; i++)
            check($sformatf("cont_gnt%0d", i), 32'(gq[i]), FIXED ? 32'd0 : 32'(i % 2));
        check("cont_ack0", 32'(n_ack0 - b_a0), FIXED ? 32'd4 : 32'd2);
        check("cont_ack1", 32'(n_ack1 - b_a1), FIXED ? 32'd0 : 32'd2);

        // Timeout: busy never rises
        model_dead = 1'b1;
        start_req(0, 0, 16'h0042, 8'h00);
        wait_ack(0, "to_ack_seen");
        #1;
        check("to_err", 32'(err), 32'd1);
        idle(1);
        check("to_err_clear", 32'(err), 32'd0);
        check("to_latency", 32'(ack_cyc - strb_cyc), 32'(START_TIMEOUT + 2));
        idle(2);
        model_dead = 1'b0;
        flash_dout = 8'h5A;
        start_req(0, 0, 16'h0043, 8'h00);
        wait_ack(0, "to_next_ack_seen");
        idle(2);
        check("to_next_err", 32'(ack_err), 32'd0);
        check("to_next_data", 32'(ack_rd), 32'h5A);

        // Busy held externally while req0 rises
        b_rd = n_rd;
        ext_busy = 1'b1;
        start_req(0, 0, 16'h00F0, 8'h00);
        idle(5);
        check("bsy_no_strobe", 32'(n_rd - b_rd), 32'd0);
        check("bsy_no_active", 32'(active), 32'd0);
        c_rel = cyc;
        ext_busy = 1'b0;
        wait_ack(0, "bsy_ack_seen");
        idle(2);
        check("bsy_strobe_cyc", 32'(strb_cyc), 32'(c_rel + 1));
        check("bsy_strobes", 32'(n_rd - b_rd), 32'd1);

        // Reset during WAIT_DONE
        busy_len = 40;
        start_req(0, 0, 16'h0555, 8'h77);
        idle(10);
        check("mid_active", 32'(active), 32'd1);
        b_a0 = n_ack0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_ctl", {25'd0, ack0, ack1, err, gnt, active, flash_read, flash_write}, 32'd0);
        check("mid_rst_dat", {rdata, flash_addr, flash_din}, 32'd0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(5);
        check("mid_no_ack", 32'(n_ack0 - b_a0), 32'd0);

        // First contended grant after reset goes to port 0
        busy_len = 3;
        addr0 = 16'h0A00; addr1 = 16'h0B00;
        req0 = 1'b1; req1 = 1'b1;
        first_seen = 1'b0; first_g = 1'b1; done0 = 1'b0; done1 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!first_seen && (flash_read || flash_write)) begin
                first_seen = 1'b1;
                first_g = gnt;
            end
            if (ack0) begin done0 = 1'b1; req0 = 1'b0; end
            if (ack1) begin done1 = 1'b1; req1 = 1'b0; end
            if (done0 && done1) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        idle(2);
        check("post_rst_first_gnt", 32'(first_g), 32'd0);
        check("post_rst_both_done", {30'd0, done0, done1}, 32'd3);
        check("no_dual_strobe", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
